led_step_scheduler: RTL and testbench



---
 rtl/led_step_scheduler.sv | 126 ++++++++++++
 tb/tb_led_step_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/led_step_scheduler.sv
// Step sequencer for the LED bar driver: manual stepping, timed auto-run and a position mirror.
// Optional LED_SCHED_AUTOSTOP_EN: auto-run pauses when the position wraps back to zero.
module led_step_scheduler #(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned PRE_W    = 26,
  parameter int unsigned STEPS    = 10
) (
  input  logic       clk,
  input  logic       sync_nreset,
  input  logic       btn_mode_debounced,
  input  logic       btn_step_debounced,
  input  logic [1:0] speed_sel,
  output logic       step_pulse,
  output logic [3:0] position,
  output logic [1:0] mode,
  output logic       tick_active
);

  localparam int unsigned POS_W = 4;
  localparam int unsigned IVL_W = 4;
  localparam int unsigned SPD_W = 2;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_PAUSED = 2'b10
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [POS_W-1:0]  position_q, position_d;
  logic              step_pulse_q, step_pulse_d;
  logic              tick_active_q, tick_active_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IVL_W-1:0]  ivl_q, ivl_d;
  logic [SPD_W-1:0]  speed_q, speed_d;

  logic              base_tick_c;
  logic              expire_c;
  logic              wrap_c;
  logic              autostop_c;
  logic [IVL_W-1:0]  interval_c;

  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      mode_q        <= MODE_MANUAL;
      position_q    <= '0;
      step_pulse_q  <= 1'b0;
      tick_active_q <= 1'b0;
      pre_q         <= '0;
      ivl_q         <= '0;
      speed_q       <= '0;
    end else begin
      mode_q        <= mode_d;
      position_q    <= position_d;
      step_pulse_q  <= step_pulse_d;
      tick_active_q <= tick_active_d;
      pre_q         <= pre_d;
      ivl_q         <= ivl_d;
      speed_q       <= speed_d;
    end
  end

  always_comb begin
    mode_d        = mode_q;
    position_d    = position_q;
    step_pulse_d  = 1'b0;
    tick_active_d = 1'b0;
    pre_d         = pre_q;
    ivl_d         = ivl_q;
    speed_d       = speed_q;
    autostop_c    = 1'b0;

    interval_c  = IVL_W'(1) << speed_q;
    base_tick_c = (pre_q == PRE_W'(PRESCALE - 1));
    expire_c    = (mode_q == MODE_AUTO) && base_tick_c &&
                  (ivl_q == IVL_W'(interval_c - IVL_W'(1)));
    wrap_c      = step_pulse_q && (position_q == POS_W'(STEPS - 1));

    // Mirror the driver: it advances on every edge that sees step_pulse.
    if (step_pulse_q) begin
      position_d = wrap_c ? '0 : position_q + POS_W'(1);
    end

`ifdef LED_SCHED_AUTOSTOP_EN
    autostop_c = wrap_c && (mode_q == MODE_AUTO);
`else
    autostop_c = 1'b0;
`endif

    // Any mode change (button or auto-stop) swallows a coincident step.
    if (btn_mode_debounced) begin
      case (mode_q)
        MODE_MANUAL: mode_d = MODE_AUTO;
        MODE_AUTO:   mode_d = MODE_PAUSED;
        default:     mode_d = MODE_MANUAL;
      endcase
    end else if (autostop_c) begin
      mode_d = MODE_PAUSED;
    end else begin
      step_pulse_d = btn_step_debounced || expire_c;
    end

    // Interval timer: idle at zero outside AUTO, restart on entry, expiry or button step.
    if (mode_d != MODE_AUTO) begin
      pre_d = '0;
      ivl_d = '0;
    end else if ((mode_q != MODE_AUTO) || btn_step_debounced || expire_c) begin
      pre_d   = '0;
      ivl_d   = '0;
      speed_d = speed_sel;
    end else if (base_tick_c) begin
      pre_d = '0;
      ivl_d = ivl_q + IVL_W'(1);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end

    tick_active_d = (mode_d == MODE_AUTO);
  end

  assign step_pulse  = step_pulse_q;
  assign position    = position_q;
  assign mode        = mode_q;
  assign tick_active = tick_active_q;

endmodule

// File: tb/tb_led_step_scheduler.sv
// Scoreboard bench for led_step_scheduler: expected step_pulse cycles are queued at stimulus time.
module tb_led_step_scheduler;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned PRE_W    = 3;
  localparam int unsigned STEPS    = 10;

`ifdef LED_SCHED_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       sync_nreset;
  logic       btn_mode_debounced;
  logic       btn_step_debounced;
  logic [1:0] speed_sel;
  logic       step_pulse;
  logic [3:0] position;
  logic [1:0] mode;
  logic       tick_active;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];

  led_step_scheduler #(
    .PRESCALE(PRESCALE),
    .PRE_W   (PRE_W),
    .STEPS   (STEPS)
  ) dut (
    .clk               (clk),
    .sync_nreset       (sync_nreset),
    .btn_mode_debounced(btn_mode_debounced),
    .btn_step_debounced(btn_step_debounced),
    .speed_sel         (speed_sel),
    .step_pulse        (step_pulse),
    .position          (position),
    .mode              (mode),
    .tick_active       (tick_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Every observed pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (step_pulse === 1'b1) begin
      if (exp_q.size() == 0) check_eq("unexpected_pulse_cycle", cyc, -1);
      else                   check_eq("pulse_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic press_step(input bit expect_pulse);
    btn_step_debounced = 1'b1;
    if (expect_pulse) exp_q.push_back(cyc + 1);
    tick(1);
    btn_step_debounced = 1'b0;
  endtask

  task automatic press_mode();
    btn_mode_debounced = 1'b1;
    tick(1);
    btn_mode_debounced = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    sync_nreset        = 1'b0;
    btn_mode_debounced = 1'b1;
    btn_step_debounced = 1'b0;
    speed_sel          = 2'd1;

    // Reset wins over a held mode button.
    tick(3);
    check_eq("rst_mode", int'(mode), 0);
    check_eq("rst_position", int'(position), 0);
    check_eq("rst_step_pulse", int'(step_pulse), 0);
    check_eq("rst_tick_active", int'(tick_active), 0);
    btn_mode_debounced = 1'b0;
    tick(1);
    sync_nreset = 1'b1;
    tick(2);

    // Manual stepping.
    for (int i = 0; i < 3; i++) begin
      press_step(1'b1);
      tick(2);
    end
    check_eq("manual_position", int'(position), 3);
    check_eq("manual_mode", int'(mode), 0);
    check_eq("manual_tick_active", int'(tick_active), 0);

    // Mode and step together: mode wins, enters AUTO, step dropped.
    btn_mode_debounced = 1'b1;
    btn_step_debounced = 1'b1;
    n = cyc + 1;
    exp_q.push_back(n + 8);
    exp_q.push_back(n + 16);
    tick(1);
    btn_mode_debounced = 1'b0;
    btn_step_debounced = 1'b0;
    check_eq("auto_mode", int'(mode), 1);
    check_eq("auto_no_pulse", int'(step_pulse), 0);
    check_eq("auto_tick_active", int'(tick_active), 1);
    wait_cyc(n + 18);
    check_eq("auto_position", int'(position), 5);

    // Button step coinciding with timer expiry: one pulse, period restarts.
    wait_cyc(n + 23);
    press_step(1'b1);
    exp_q.push_back(n + 32);
    // Mid-interval button step restarts the interval.
    wait_cyc(n + 35);
    press_step(1'b1);
    exp_q.push_back(n + 44);
    // Leaving AUTO on the expiry edge suppresses the timed pulse.
    wait_cyc(n + 51);
    press_mode();
    check_eq("paused_mode", int'(mode), 2);
    check_eq("paused_tick_active", int'(tick_active), 0);
    wait_cyc(n + 60);
    check_eq("paused_position", int'(position), 9);

    // Ten manual steps from 9 in PAUSED: wrap once, end at 9.
    for (int i = 0; i < 10; i++) begin
      press_step(1'b1);
      tick(2);
      if (i == 0) check_eq("wrap_position", int'(position), 0);
    end
    check_eq("wrap_end_position", int'(position), 9);
    check_eq("wrap_mode", int'(mode), 2);

    // PAUSED -> MANUAL -> AUTO from position 9.
    press_mode();
    tick(1);
    check_eq("cycle_manual_mode", int'(mode), 0);
    btn_mode_debounced = 1'b1;
    n2 = cyc + 1;
    exp_q.push_back(n2 + 8);
    if (!AUTOSTOP) exp_q.push_back(n2 + 16);
    tick(1);
    btn_mode_debounced = 1'b0;
    wait_cyc(n2 + 20);
    check_eq("autostop_mode", int'(mode), AUTOSTOP ? 2 : 1);
    check_eq("autostop_position", int'(position), AUTOSTOP ? 0 : 1);
    if (!AUTOSTOP) begin
      press_mode();
      tick(1);
    end
    wait_cyc(n2 + 40);
    check_eq("stopped_mode", int'(mode), 2);

    // Reset one cycle after a step press kills the pending pulse's effect.
    press_step(1'b1);
    tick(2);
    check_eq("pre_reset_position", int'(position), AUTOSTOP ? 1 : 2);
    press_step(1'b1);
    sync_nreset = 1'b0;
    tick(1);
    check_eq("reset_step_pulse", int'(step_pulse), 0);
    check_eq("reset_position", int'(position), 0);
    check_eq("reset_mode", int'(mode), 0);
    check_eq("reset_tick_active", int'(tick_active), 0);
    sync_nreset = 1'b1;
    tick(4);
    check_eq("post_reset_position", int'(position), 0);
    check_eq("scoreboard_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
